// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller and its BTB.
package branch_redirect_ctrl_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_REDIRECT = 1'b1;

    // Tag holds pc[31:2] shifted down by the index width; the unused top bits stay zero.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } btb_entry_t;

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        logic [1:0] r;
        r = c;
        if (up && c != 2'b11) r = c + 2'd1;
        else if (!up && c != 2'b00) r = c - 2'd1;
        return r;
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_btb_table.sv
// Direct-mapped BTB: async lookup on the fetch PC, read-modify-write update from EX.
module btb_table
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rd_pc,
    output logic        rd_hit,
    output logic [1:0]  rd_ctr,
    output logic [31:0] rd_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int IW = $clog2(ENTRIES);

    btb_entry_t mem [ENTRIES];

    function automatic logic [29:0] tag_of(input logic [31:0] pc);
        return pc[31:2] >> IW;
    endfunction

    logic [IW-1:0] rd_idx;
    logic [IW-1:0] upd_idx;
    btb_entry_t    rd_entry;
    btb_entry_t    upd_cur;
    logic          upd_hit;

    assign rd_idx    = rd_pc[IW+1:2];
    assign rd_entry  = mem[rd_idx];
    assign rd_hit    = rd_entry.valid && (rd_entry.tag == tag_of(rd_pc));
    assign rd_ctr    = rd_entry.ctr;
    assign rd_target = rd_entry.target;

    assign upd_idx = upd_pc[IW+1:2];
    assign upd_cur = mem[upd_idx];
    assign upd_hit = upd_cur.valid && (upd_cur.tag == tag_of(upd_pc));

    // Lookups see the pre-update contents; the write lands on the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                mem[upd_idx].ctr <= ctr_step(upd_cur.ctr, upd_taken);
                if (upd_taken) mem[upd_idx].target <= upd_target;
            end else if (upd_taken) begin
                mem[upd_idx] <= '{valid: 1'b1, tag: tag_of(upd_pc), target: upd_target, ctr: 2'b10};
            end
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Resolves EX branches/jumps, detects mispredicts and holds a redirect to IF until accepted.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_jump,
    input  logic [2:0]  ex_func3,
    input  logic [31:0] ex_data1,
    input  logic [31:0] ex_data2,
    input  logic [31:0] ex_target,
    input  logic [31:0] ex_pc,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    logic [0:0]  state;
    logic        lk_hit;
    logic [1:0]  lk_ctr;
    logic [31:0] lk_target;
    logic        resolve;
    logic        taken;
    logic        mispredict;
    logic [31:0] actual_pc;

    btb_table #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_pc      (if_pc),
        .rd_hit     (lk_hit),
        .rd_ctr     (lk_ctr),
        .rd_target  (lk_target),
        .upd_en     (resolve),
        .upd_pc     (ex_pc),
        .upd_taken  (taken),
        .upd_target (ex_target)
    );

    assign pred_taken  = lk_hit && lk_ctr[1];
    assign pred_target = lk_hit ? lk_target : if_pc + 32'd4;

    // While a redirect is pending, EX holds wrong-path work and is ignored.
    assign resolve = (state == ST_IDLE) && ex_valid && (ex_branch || ex_jump);

    always_comb begin
        taken = 1'b0;
        if (ex_jump) begin
            taken = 1'b1;
        end else begin
            case (ex_func3)
                F3_BEQ:  taken = (ex_data1 == ex_data2);
                F3_BNE:  taken = (ex_data1 != ex_data2);
                F3_BLT:  taken = ($signed(ex_data1) <  $signed(ex_data2));
                F3_BGE:  taken = ($signed(ex_data1) >= $signed(ex_data2));
                F3_BLTU: taken = (ex_data1 <  ex_data2);
                F3_BGEU: taken = (ex_data1 >= ex_data2);
                default: taken = 1'b0;
            endcase
        end
    end

    assign actual_pc  = taken ? ex_target : ex_pc + 32'd4;
    assign mispredict = (taken != ex_pred_taken) || (taken && (ex_pred_target != ex_target));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (resolve && mispredict) begin
                        state          <= ST_REDIRECT;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= actual_pc;
                    end
                end
                default: begin
                    if (redirect_ready) begin
                        state          <= ST_IDLE;
                        redirect_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign flush_ifid = (state == ST_REDIRECT);
    assign flush_idex = (state == ST_REDIRECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (resolve) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (mispredict) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule
